// File: rtl/mux6_bus_arbiter.sv
// mux6_bus_arbiter: round-robin owner arbitration for the shared 6:1 result mux.
// Grants one requester at a time, drives the mux select and holds the grant until
// the owner releases it. Optional hold limit enabled by defining ARB_TIMEOUT_EN.
module mux6_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] req,
    input  logic [5:0] done,
    output logic [5:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout
);

    // Reject out-of-range hold limits at elaboration.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 2..255");
    end

    typedef enum logic {StIdle, StOwn} state_e;

    state_e     state_q, state_d;
    logic [5:0] grant_q, grant_d;
    logic [2:0] sel_q,   sel_d;
    logic       busy_q,  busy_d;
    logic [2:0] ptr_q,   ptr_d;
    logic       found;
    logic [2:0] win;
    logic [3:0] idx;
    logic       release_own;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    // First requester at or after ptr, wrapping 5 -> 0.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        idx   = 4'd0;
        for (int i = 0; i < 6; i++) begin
            idx = {1'b0, ptr_q} + 4'(i);
            if (idx >= 4'd6) begin
                idx = idx - 4'd6;
            end
            if (!found && req[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
    end

    // Owner drops the bus on its own done strobe or by withdrawing its request.
    assign release_own = done[sel_q] || !req[sel_q];

    // Next-state logic for ownership, select, pointer and hold counter.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StOwn;
                    grant_d = 6'b000001 << win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    ptr_d   = (win == 3'd5) ? 3'd0 : win + 3'd1;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            StOwn: begin
                // sel deliberately keeps the owner index after release.
                if (release_own) begin
                    state_d = StIdle;
                    grant_d = 6'b0;
                    busy_d  = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q >= HoldLast) begin
                    // Held for MAX_HOLD cycles: revoke; a real release wins over this.
                    state_d   = StIdle;
                    grant_d   = 6'b0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            grant_q <= 6'b0;
            sel_q   <= 3'd0;
            busy_q  <= 1'b0;
            ptr_q   <= 3'd0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux6_bus_arbiter.sv
// Testbench for mux6_bus_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level ownership model.
module tb_mux6_bus_arbiter;

    localparam int unsigned TbMaxHold = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [5:0] req;
    logic [5:0] done;
    logic [5:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index (-1 = none), rotation pointer, last select,
    // cycles held in the current grant, and the timeout pulse.
    int m_owner;
    int m_ptr;
    int m_sel;
    int m_held;
    bit m_timeout;

    mux6_bus_arbiter #(
        .MAX_HOLD(TbMaxHold)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .sel    (sel),
        .busy   (busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] exp_grant();
        return (m_owner < 0) ? 6'b0 : 6'(1 << m_owner);
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_sel     = 0;
        m_held    = 0;
        m_timeout = 1'b0;
    endtask

    // One rising edge: advance the model with the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            for (int j = 0; j < 6; j++) begin
                int c;
                c = (m_ptr + j) % 6;
                if (req[c]) begin
                    m_owner = c;
                    m_sel   = c;
                    m_ptr   = (c + 1) % 6;
                    m_held  = 0;
                    break;
                end
            end
        end else if (done[m_owner] || !req[m_owner]) begin
            m_owner = -1;
        end else begin
            m_held++;
            if (TimeoutEn && m_held >= TbMaxHold) begin
                m_owner   = -1;
                m_timeout = 1'b1;
            end
        end
        #1;
    endtask

    // Async reset pulse placed between clock edges.
    task automatic do_reset();
        reset_n = 1'b0;
        req     = 6'b0;
        done    = 6'b0;
        model_reset();
        #3;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        req = 6'b000100;
        tick();
        checks++;
        if (grant !== 6'b000100) begin
            failures++;
            $display("FAIL reset_pre_grant: grant=%b want 000100", grant);
        end
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (grant !== 6'b0 || sel !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: grant=%b sel=%0d busy=%b timeout=%b want 000000/0/0/0",
                     grant, sel, busy, timeout);
        end
        req = 6'b000001;
        #2;
        reset_n = 1'b1;
        tick();
        checks++;
        if (grant !== 6'b000001 || sel !== 3'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_regrant: grant=%b sel=%0d busy=%b want 000001/0/1",
                     grant, sel, busy);
        end
        req = 6'b0;
        tick();
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req = 6'b001000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant !== 6'b001000 || sel !== 3'd3 || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_hold[%0d]: grant=%b sel=%0d busy=%b want 001000/3/1",
                         i, grant, sel, busy);
            end
        end
        done = 6'b001000;
        tick();
        checks++;
        if (grant !== 6'b0 || sel !== 3'd3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release: grant=%b sel=%0d busy=%b want 000000/3/0",
                     grant, sel, busy);
        end
        done = 6'b0;
        req  = 6'b0;
        tick();
        checks++;
        if (grant !== 6'b0 || sel !== 3'd3) begin
            failures++;
            $display("FAIL single_sel_keep: grant=%b sel=%0d want 000000/3", grant, sel);
        end
    endtask

    task automatic test_contention();
        logic [2:0] seen[$];
        do_reset();
        req = 6'b111111;
        for (int t = 0; t < 40 && seen.size() < 7; t++) begin
            tick();
            checks++;
            if (grant !== exp_grant() || sel !== 3'(m_sel) || busy !== (m_owner >= 0)) begin
                failures++;
                $display("FAIL contention_cycle[%0d]: grant=%b sel=%0d busy=%b want %b/%0d/%b",
                         t, grant, sel, busy, exp_grant(), m_sel, m_owner >= 0);
            end
            if (m_owner >= 0 && done == 6'b0) begin
                seen.push_back(sel);
                done = 6'(1 << m_owner);
            end else begin
                done = 6'b0;
            end
        end
        checks++;
        if (seen.size() != 7) begin
            failures++;
            $display("FAIL contention_count: grants=%0d want 7", seen.size());
        end
        for (int i = 0; i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== 3'(i % 6)) begin
                failures++;
                $display("FAIL contention_order[%0d]: sel=%0d want %0d", i, seen[i], i % 6);
            end
        end
        done = 6'b0;
        req  = 6'b0;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 6'b010000;
        tick();
        req = 6'b0;
        tick();
        req = 6'b010001;
        tick();
        checks++;
        if (grant !== 6'b000001 || sel !== 3'd0) begin
            failures++;
            $display("FAIL wrap: grant=%b sel=%0d want 000001/0", grant, sel);
        end
        req = 6'b0;
        tick();
        tick();
    endtask

    task automatic test_noise();
        do_reset();
        req = 6'b000100;
        tick();
        for (int i = 0; i < 3; i++) begin
            done = 6'b000001 | (6'($urandom) & 6'b111010);
            req  = 6'b000100 | (6'($urandom) & 6'b111010) | 6'(i % 2);
            tick();
            checks++;
            if (grant !== 6'b000100 || busy !== 1'b1) begin
                failures++;
                $display("FAIL noise[%0d]: grant=%b busy=%b want 000100/1", i, grant, busy);
            end
        end
        done = 6'b0;
        req  = 6'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 6'b000011;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (grant !== 6'b000001 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL timeout_hold[%0d]: grant=%b timeout=%b want 000001/0",
                         i, grant, timeout);
            end
        end
        tick();
        checks++;
        if (grant !== 6'b0 || timeout !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_revoke: grant=%b timeout=%b busy=%b want 000000/1/0",
                     grant, timeout, busy);
        end
        tick();
        checks++;
        if (grant !== 6'b000010 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_next: grant=%b timeout=%b want 000010/0", grant, timeout);
        end
        tick();
        tick();
        tick();
        done = 6'b000010;
        tick();
        checks++;
        if (grant !== 6'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_vs_release: grant=%b timeout=%b want 000000/0",
                     grant, timeout);
        end
`else
        for (int i = 0; i < 120; i++) begin
            tick();
            checks++;
            if (grant !== 6'b000001 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL hold_forever[%0d]: grant=%b timeout=%b want 000001/0",
                         i, grant, timeout);
            end
        end
`endif
        done = 6'b0;
        req  = 6'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 6'($urandom);
            end
            done = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            tick();
            checks++;
            if (grant !== exp_grant() || sel !== 3'(m_sel) || busy !== (m_owner >= 0) ||
                timeout !== m_timeout) begin
                failures++;
                $display("FAIL random[%0d]: grant=%b sel=%0d busy=%b to=%b want %b/%0d/%b/%b",
                         t, grant, sel, busy, timeout, exp_grant(), m_sel, m_owner >= 0,
                         m_timeout);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 6'b0;
        done    = 6'b0;
        model_reset();
        #2;
        checks++;
        if (grant !== 6'b0 || sel !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: grant=%b sel=%0d busy=%b timeout=%b want all zero",
                     grant, sel, busy, timeout);
        end
        #10;
        reset_n = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_noise();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux6_bus_arbiter.md
# mux6_bus_arbiter

Round-robin arbiter that shares the 32-bit six-input result mux (the 6:1 source selector feeding the shared datapath bus) among six requesters. It grants ownership to one requester at a time, drives the mux's 3-bit select, and holds the grant until the owner releases it or, optionally, a hold limit expires. It sits between the requesting units and the mux, and is the only driver of the mux select.

## Interface
- MAX_HOLD, 16: maximum consecutive owned cycles per grant; used only when ARB_TIMEOUT_EN is defined. Legal range is 2..255.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req  input  6  request vector; bit i = requester i (mux input d(i+1))
- done  input  6  release strobe; bit i is meaningful only while requester i owns the bus
- grant  output  6  one-hot ownership; all zero when nobody owns the bus
- sel  output  3  mux select; owner index 0..5, never 6 or 7
- busy  output  1  high while any grant is asserted
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit

## Operation
- All outputs are registered. Reset values:
  - grant = 6'b0
  - sel = 3'b000
  - busy = 0
  - timeout = 0
  - internal round-robin pointer ptr = 0
  - hold counter = 0
- There are two states, IDLE and OWN.
- **IDLE:**
  - If req is nonzero, pick the first set bit scanning ptr, ptr+1, …, wrapping from 5 to 0.
  - Then set grant to that one-hot bit, sel to its index, busy to 1, and ptr to (index+1) mod 6. Go to OWN.
  - If req is zero, stay in IDLE. sel keeps its last value.
- **OWN** (owner k):
  - Release condition: done[k]=1, or req[k]=0. On release: grant=0, busy=0, go to IDLE.
  - done and req bits of non-owners are ignored while in OWN.
  - sel holds k through the release cycle and afterwards, until the next grant.
- **Turnaround:** after every release, at least one IDLE cycle with grant=0 before the next grant. Back-to-back grants are illegal.
- **Fairness:** with all six requesting continuously, grants rotate 0,1,2,3,4,5,0,…
- **Reset mid-ownership:** all outputs and ptr return to their reset values immediately (asynchronously). No release handshake is required.

## Timing
- **Grant latency:**
  - req seen high at rising edge N while in IDLE → grant/sel/busy valid after edge N.
  - Consumers use the bus from cycle N+1.
- **Release latency:** done[k] or !req[k] sampled at edge M → grant=0 after edge M.
- **Next grant:** earliest after edge M+1.
- **Hold counter:**
  - Clears to 0 on grant and increments each OWN cycle.
  - Saturates at MAX_HOLD-1; 8 bits wide.
- **Simultaneous release and timeout on the same edge:** treat as a normal release; timeout stays 0.
- A requester that drops req and reasserts it during the turnaround cycle competes normally, from the updated ptr.

## Configuration
- **ARB_TIMEOUT_EN defined:**
  - When the owner has held the bus for MAX_HOLD consecutive cycles without releasing, the grant is revoked on that edge.
  - timeout pulses high for exactly one cycle, and the block goes to IDLE as a normal release.
  - Requester k must then re-win arbitration; ptr has already advanced past k.
- **ARB_TIMEOUT_EN undefined:**
  - No hold counter is built and the owner holds indefinitely.
  - timeout is tied to 0.

## Test plan
- Reset check:
  - Assert reset_n=0 mid-run with grant=6'b000100 → grant=0, sel=0, busy=0 immediately.
  - After releasing reset with req=6'b000001 → grant=6'b000001 one edge later.
- Single requester: req=6'b001000 held for 3 cycles, then done[3] pulses.
  - grant=6'b001000 and sel=3 from the first edge.
  - grant=0 after the done edge; sel stays 3.
- Full contention: req=6'b111111 constant, each owner pulses done one cycle after its grant.
  - sel sequence 0,1,2,3,4,5,0.
  - An idle cycle with grant=0 between every pair.
- Pointer wrap: ptr=5 (after granting 4), req=6'b010001 → grant goes to requester 0 before 4.
- Non-owner noise: owner 2, done=6'b000001 and req[0] toggling → grant stays 6'b000100.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=6'b000011 held, no done.
  - Owner 0 is revoked after 4 OWN cycles, with timeout pulsed 1 cycle.
  - Requester 1 is granted after the turnaround cycle.
  - Without the macro, owner 0 holds for 100+ cycles and timeout stays 0.
